// File: rtl/req_ack_initiator.sv
// Upstream initiator: buffers valid/ready commands in a small FIFO and issues each one
// to a responder as a four-phase req/ack handshake with latency, count and timeout reporting.
module req_ack_initiator #(
    parameter int DW      = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16,
    parameter int LW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    input  logic [DW-1:0] cmd_data,
    output logic          cmd_ready,
    output logic          req,
    output logic [DW-1:0] req_data,
    input  logic          ack,
    output logic          busy,
    output logic          timeout,
    output logic [LW-1:0] last_latency,
    output logic [15:0]   done_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

    state_t        state, state_d;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop;
    logic          xfer_ok, abort;
    logic          req_d;
    logic [DW-1:0] req_data_d;
    logic [LW-1:0] cnt, cnt_d;

    assign cmd_ready = (count != (AW+1)'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE) || (count != '0);

    // Payload storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Handshake sequencing. The ack guard on the IDLE pop keeps req from rising
    // while the responder still drives ack high (e.g. straight out of reset).
    always_comb begin
        state_d    = state;
        req_d      = req;
        req_data_d = req_data;
        cnt_d      = cnt;
        pop        = 1'b0;
        xfer_ok    = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if ((count != '0) && !ack) begin
                    pop        = 1'b1;
                    req_d      = 1'b1;
                    req_data_d = mem[rd_ptr];
                    cnt_d      = LW'(1);
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    req_d   = 1'b0;
                    xfer_ok = 1'b1;
                    state_d = RELEASE;
                end else if (cnt == LW'(TIMEOUT)) begin
                    req_d   = 1'b0;
                    abort   = 1'b1;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt + LW'(1);
                end
            end
            RELEASE: begin
                if (!ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            req      <= 1'b0;
            req_data <= '0;
            cnt      <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_d;
            req      <= req_d;
            req_data <= req_data_d;
            cnt      <= cnt_d;
            timeout  <= abort;
        end
    end

    // Status registers only move on a completed transfer; aborts leave them untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_latency <= '0;
            done_count   <= '0;
        end else if (xfer_ok) begin
            last_latency <= cnt;
            done_count   <= done_count + 16'd1;
        end
    end

endmodule
